// File: rtl/wb2core.sv
// wb2core: Wishbone B4 pipelined slave re-issuing transfers on an Ibex-style core port.
//
// Ports:
//   i_clk, i_rst_n                  clock, synchronous active-low reset
//   i_wb_cyc/stb/we/adr/sel/dat_m   Wishbone request from the initiator
//   o_wb_dat_s/ack/err/stall        Wishbone response and pipeline stall
//   o_core_req/we/addr/be/wdata     core request, driven from a one-entry hold register
//   i_core_gnt                      core grant
//   i_core_rvalid/rdata/err         in-order core response (reads and writes)
module wb2core #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_adr,
  input  logic [DW/8-1:0] i_wb_sel,
  input  logic [DW-1:0]   i_wb_dat_m,
  output logic [DW-1:0]   o_wb_dat_s,
  output logic            o_wb_ack,
  output logic            o_wb_err,
  output logic            o_wb_stall,
  output logic            o_core_req,
  input  logic            i_core_gnt,
  output logic            o_core_we,
  output logic [AW-1:0]   o_core_addr,
  output logic [DW/8-1:0] o_core_be,
  output logic [DW-1:0]   o_core_wdata,
  input  logic            i_core_rvalid,
  input  logic [DW-1:0]   i_core_rdata,
  input  logic            i_core_err
);
  localparam logic [3:0] MAXO = 4'(MAX_OUTSTANDING);
  logic            r_hold_valid;
  logic            r_drop;
  logic            r_we;
  logic [AW-1:0]   r_adr;
  logic [DW/8-1:0] r_sel;
  logic [DW-1:0]   r_dat;
  logic [3:0]      r_p;
  logic [3:0]      r_d;
  logic            w_gnt;
  logic            w_rv;
  logic            w_accept;
  logic            w_abort;
  logic            w_drop_nxt;
  logic [3:0]      w_occ;
  logic [3:0]      w_p_nxt;
  logic [3:0]      w_d_nxt;
  always_comb begin
    w_gnt      = r_hold_valid & i_core_gnt;
    // a response with nothing outstanding is a protocol violation and is ignored
    w_rv       = i_core_rvalid & (r_p != 4'd0);
    w_occ      = r_p + {3'd0, r_hold_valid};
    // a response this cycle frees a slot, so a full pipeline can still accept
    o_wb_stall = (r_hold_valid & ~i_core_gnt) | ((w_occ >= MAXO) & ~w_rv);
    w_accept   = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    w_abort    = ~i_wb_cyc & ((r_p != 4'd0) | r_hold_valid);
    w_p_nxt    = r_p + {3'd0, w_gnt} - {3'd0, w_rv};
    // on abort every granted request (including one granted now) must be drained;
    // an ungranted held entry is counted later, when its grant arrives
    w_d_nxt    = w_abort ? w_p_nxt
               : r_d + {3'd0, r_drop & w_gnt} - {3'd0, w_rv & (r_d != 4'd0)};
    w_drop_nxt = w_accept ? 1'b0
               : (w_abort & r_hold_valid & ~i_core_gnt) ? 1'b1
               : w_gnt ? 1'b0 : r_drop;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hold_valid <= 1'b0;
      r_drop       <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_sel        <= '0;
      r_dat        <= '0;
      r_p          <= '0;
      r_d          <= '0;
    end else begin
      r_hold_valid <= w_accept | (r_hold_valid & ~i_core_gnt);
      r_drop       <= w_drop_nxt;
      r_p          <= w_p_nxt;
      r_d          <= w_d_nxt;
      if (w_accept) begin
        r_we  <= i_wb_we;
        r_adr <= i_wb_adr;
        r_sel <= i_wb_sel;
        r_dat <= i_wb_dat_m;
      end
    end
  end
  assign o_core_req   = r_hold_valid;
  assign o_core_we    = r_we;
  assign o_core_addr  = r_adr;
  assign o_core_be    = r_sel;
  assign o_core_wdata = r_dat;
  assign o_wb_dat_s   = i_core_rdata;
  // responses owed to an aborted cycle are swallowed until the drain count hits zero
  assign o_wb_ack     = w_rv & ~i_core_err & (r_d == 4'd0) & i_wb_cyc;
  assign o_wb_err     = w_rv & i_core_err & (r_d == 4'd0) & i_wb_cyc;
endmodule

// File: tb/tb_wb2core.sv
// tb_wb2core: randomized and directed self-checking bench for wb2core against a queue model.
module tb_wb2core;
  localparam int MAXO = 2;
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    bit          dead;
  } req_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat_m = '0, rdata = '0;
  logic [3:0]  sel = '0;
  logic        gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
  logic [31:0] dat_s, caddr, cwdata;
  logic        ack, werr, stall, req, cwe;
  logic [3:0]  cbe;
  int          checks = 0;
  int          errors = 0;
  int          drop_cnt = 0;
  req_t        req_q[$];
  bit          rsp_q[$];

  always #5 clk = ~clk;

  wb2core #(.AW(32), .DW(32), .MAX_OUTSTANDING(MAXO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_adr(adr),
    .i_wb_sel(sel), .i_wb_dat_m(dat_m), .o_wb_dat_s(dat_s),
    .o_wb_ack(ack), .o_wb_err(werr), .o_wb_stall(stall),
    .o_core_req(req), .i_core_gnt(gnt), .o_core_we(cwe),
    .o_core_addr(caddr), .o_core_be(cbe), .o_core_wdata(cwdata),
    .i_core_rvalid(rvalid), .i_core_rdata(rdata), .i_core_err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Checks one cycle at the negedge, then advances the model by the handshakes
  // that the coming posedge will commit.
  task automatic step();
    bit hold, rv_eff, exp_stall, dead0;
    int p;
    @(negedge clk);
    hold      = req_q.size() != 0;
    p         = rsp_q.size();
    rv_eff    = rvalid && p > 0;
    dead0     = p > 0 ? rsp_q[0] : 1'b0;
    exp_stall = (hold && !gnt) || ((p + int'(hold)) >= MAXO && !rv_eff);
    chk("core_req", req, hold);
    if (hold) begin
      chk("core_addr", caddr, req_q[0].adr);
      chk("core_we", cwe, req_q[0].we);
      chk("core_be", cbe, req_q[0].sel);
      chk("core_wdata", cwdata, req_q[0].dat);
    end
    chk("wb_stall", stall, exp_stall);
    chk("wb_ack", ack, rv_eff && !err && !dead0 && cyc);
    chk("wb_err", werr, rv_eff && err && !dead0 && cyc);
    if (rv_eff && !err && !dead0 && cyc) chk("wb_dat_s", dat_s, rdata);
    if (!rst_n) begin
      req_q.delete();
      rsp_q.delete();
    end else begin
      if (rv_eff) void'(rsp_q.pop_front());
      if (hold && gnt) rsp_q.push_back(req_q.pop_front().dead);
      if (!cyc) begin
        foreach (req_q[i]) req_q[i].dead = 1'b1;
        foreach (rsp_q[i]) rsp_q[i] = 1'b1;
      end
      if (cyc && stb && !exp_stall) req_q.push_back('{we, adr, sel, dat_m, 1'b0});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic c, input logic s, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d, input logic g,
                     input logic rv, input logic [31:0] rd, input logic e);
    cyc = c; stb = s; we = w; adr = a; sel = b; dat_m = d;
    gnt = g; rvalid = rv; rdata = rd; err = e;
    step();
  endtask

  initial begin
    @(posedge clk);
    #1;
    step();
    rst_n = 1'b1;
    // single read at 0x100, granted at once, data two cycles after grant
    drv(1, 1, 0, 32'h100, 4'hf, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd_ack_pre", ack, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
    // write with grant withheld three cycles
    drv(1, 1, 1, 32'h40, 4'b0011, 32'h1234, 0, 0, 0, 0);
    repeat (3) drv(1, 1, 0, 32'h999, 4'hf, 32'h5555, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // read answered with an error
    drv(1, 1, 0, 32'h200, 4'hf, 0, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 32'hBAD, 1);
    // two reads granted, cycle dropped, new read acked only on the third response
    drv(1, 1, 0, 32'h10, 4'hf, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 32'h14, 4'hf, 0, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 32'h18, 4'hf, 0, 0, 1, 32'h1, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 1, 32'h2, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 32'h3, 0);
    // abort while held and ungranted: request stays until grant, response discarded
    drv(1, 1, 1, 32'h80, 4'hf, 32'hAA, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 32'h84, 4'hf, 0, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 1, 32'h7, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 32'h8, 0);
    // stray response with nothing outstanding
    drv(1, 0, 0, 0, 0, 0, 0, 1, 32'h9, 0);
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cyc = 1'b1; stb = 1'b0; gnt = 1'b0; rvalid = 1'b1; err = 1'b0;
        #1;
        chk("rst_core_req", req, 0);
        chk("rst_core_addr", caddr, 0);
        chk("rst_core_be", cbe, 0);
        chk("rst_core_wdata", cwdata, 0);
        chk("rst_core_we", cwe, 0);
        chk("rst_stall", stall, 0);
        chk("rst_late_ack", ack, 0);
        chk("rst_late_err", werr, 0);
      end
      if (drop_cnt > 0) begin
        cyc = 1'b0;
        drop_cnt--;
      end else begin
        cyc = 1'b1;
        if ($urandom_range(0, 39) == 0) drop_cnt = $urandom_range(1, 3);
      end
      stb    = $urandom_range(0, 2) != 0;
      we     = 1'($urandom_range(0, 1));
      adr    = $urandom;
      sel    = 4'($urandom);
      dat_m  = $urandom;
      gnt    = $urandom_range(0, 3) != 0;
      rvalid = rsp_q.size() > 0 ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      rdata  = $urandom;
      err    = $urandom_range(0, 5) == 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
